// File: rtl/m_unit_arbiter.sv
// Shares one RV32-M multiply/divide unit between two requesters: round-robin
// grant, operands held for the whole operation, per-requester result buffers.
module m_unit_arbiter #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [1:0]        i_req_valid,
    output logic [1:0]        o_req_ready,
    input  logic [2*XLEN-1:0] i_req_rs1,
    input  logic [2*XLEN-1:0] i_req_rs2,
    input  logic [5:0]        i_req_f3,
    output logic [1:0]        o_rsp_valid,
    input  logic [1:0]        i_rsp_ready,
    output logic [2*XLEN-1:0] o_rsp_res,
    output logic [1:0]        o_rsp_err,
    output logic              o_m_en,
    output logic [XLEN-1:0]   o_m_rs1,
    output logic [XLEN-1:0]   o_m_rs2,
    output logic [2:0]        o_m_f3,
    input  logic [XLEN-1:0]   i_m_res,
    input  logic              i_m_stall,
    output logic              o_busy
);
    localparam int CW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        COOL  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            rr_ptr_q;
    logic            owner_q;
    logic [CW-1:0]   cnt_q;
    logic [1:0]      eligible;
    logic [1:0]      grant;
    logic            grant_id;
    logic            accept;
    logic            done_ok;
    logic            done_to;
    logic [XLEN-1:0] res_next;

    // A requester still holding an unconsumed result must not be granted again.
    assign eligible = i_req_valid & ~o_rsp_valid;

    always_comb begin
        grant = eligible;
        if (eligible == 2'b11) begin
            grant = rr_ptr_q ? 2'b10 : 2'b01;
        end
    end

    assign grant_id = grant[1];
    assign accept   = (state_q == IDLE) && (grant != 2'b00);
    assign done_ok  = (state_q == ISSUE) && !i_m_stall;
    assign done_to  = (state_q == ISSUE) && i_m_stall && (cnt_q == CW'(TIMEOUT - 1));
    assign res_next = done_to ? '0 : i_m_res;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ISSUE;
            ISSUE:   if (done_ok || done_to) state_d = COOL;
            COOL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        o_req_ready = 2'b00;
        o_m_en      = 1'b0;
        o_busy      = 1'b1;
        case (state_q)
            IDLE: begin
                o_req_ready = grant;
                o_busy      = 1'b0;
            end
            ISSUE:   o_m_en = 1'b1;
            default: ;
        endcase
    end

    // Operands are captured once at accept and held until the next accept.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            rr_ptr_q <= 1'b0;
            owner_q  <= 1'b0;
            cnt_q    <= '0;
            o_m_rs1  <= '0;
            o_m_rs2  <= '0;
            o_m_f3   <= '0;
        end else begin
            if (accept) begin
                owner_q  <= grant_id;
                rr_ptr_q <= ~grant_id;
                o_m_rs1  <= grant_id ? i_req_rs1[XLEN +: XLEN] : i_req_rs1[0 +: XLEN];
                o_m_rs2  <= grant_id ? i_req_rs2[XLEN +: XLEN] : i_req_rs2[0 +: XLEN];
                o_m_f3   <= grant_id ? i_req_f3[3 +: 3] : i_req_f3[0 +: 3];
            end
            case (state_q)
                ISSUE:   cnt_q <= cnt_q + CW'(1);
                COOL:    cnt_q <= '0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            o_rsp_valid <= '0;
            o_rsp_err   <= '0;
            o_rsp_res   <= '0;
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (o_rsp_valid[n] && i_rsp_ready[n]) begin
                    o_rsp_valid[n] <= 1'b0;
                end
            end
            if (done_ok || done_to) begin
                o_rsp_valid[owner_q] <= 1'b1;
                o_rsp_err[owner_q]   <= done_to;
                if (owner_q) begin
                    o_rsp_res[XLEN +: XLEN] <= res_next;
                end else begin
                    o_rsp_res[0 +: XLEN] <= res_next;
                end
            end
        end
    end

endmodule
